// File: rtl/jk_edge_counter.sv
// Edge detector and windowed rising-edge counter for the Q output of a JK flop.
// A measurement is armed by START, runs WINDOW cycles, and its result is held with VALID/ACK.
module jk_edge_counter #(
  parameter int WIDTH  = 4,
  parameter int WINDOW = 8
) (
  input  logic             CK,
  input  logic             CLR,
  input  logic             Q_in,
  input  logic             START,
  input  logic             ACK,
  output logic             RISE,
  output logic             FALL,
  output logic             BUSY,
  output logic             VALID,
  output logic [WIDTH-1:0] COUNT,
  output logic             OVF
);

  localparam int TW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [TW-1:0]    TMR_LOAD = TW'(WINDOW - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic             q_d;
  logic             rise_now, fall_now;
  logic [WIDTH-1:0] cnt, cnt_nx, cnt_sat;
  logic             ovf_i, ovf_nx, sat_hit;
  logic [TW-1:0]    timer, timer_nx;
  logic [WIDTH-1:0] count_nx;
  logic             ovf_out_nx;

  assign rise_now = Q_in & ~q_d;
  assign fall_now = ~Q_in & q_d;

  // Saturating increment; an edge seen while already at max only marks overflow.
  always_comb begin
    sat_hit = rise_now && (cnt == CNT_MAX);
    cnt_sat = cnt;
    if (rise_now && !sat_hit) cnt_sat = cnt + 1'b1;
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    ovf_nx     = ovf_i;
    timer_nx   = timer;
    count_nx   = COUNT;
    ovf_out_nx = OVF;
    case (state)
      IDLE: begin
        if (START) begin
          state_nx = RUN;
          cnt_nx   = '0;
          ovf_nx   = 1'b0;
          timer_nx = TMR_LOAD;
        end
      end
      RUN: begin
        cnt_nx   = cnt_sat;
        ovf_nx   = ovf_i | sat_hit;
        timer_nx = timer - 1'b1;
        // Last window edge: its own rising edge is still part of the result.
        if (timer == '0) begin
          count_nx   = cnt_sat;
          ovf_out_nx = ovf_i | sat_hit;
          state_nx   = DONE;
        end
      end
      DONE: begin
        if (ACK) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (!CLR) begin
      state <= IDLE;
      q_d   <= Q_in;
      RISE  <= 1'b0;
      FALL  <= 1'b0;
      BUSY  <= 1'b0;
      VALID <= 1'b0;
      COUNT <= '0;
      OVF   <= 1'b0;
      cnt   <= '0;
      ovf_i <= 1'b0;
      timer <= '0;
    end else begin
      state <= state_nx;
      q_d   <= Q_in;
      RISE  <= rise_now;
      FALL  <= fall_now;
      BUSY  <= (state_nx == RUN);
      VALID <= (state_nx == DONE);
      COUNT <= count_nx;
      OVF   <= ovf_out_nx;
      cnt   <= cnt_nx;
      ovf_i <= ovf_nx;
      timer <= timer_nx;
    end
  end

endmodule

// File: tb/tb_jk_edge_counter.sv
// Bench for jk_edge_counter: two instances (4-bit/8-cycle and 2-bit/16-cycle) share stimulus
// and are checked every cycle against a transaction-level model of the measurement.
module tb_jk_edge_counter;

  logic       CK = 1'b0;
  logic       CLR = 1'b0, Q_in = 1'b0, START = 1'b0, ACK = 1'b0;
  logic [1:0] rise, fall, busy, valid, ovf;
  logic [3:0] count_a;
  logic [1:0] count_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #10 CK = ~CK;

  jk_edge_counter #(.WIDTH(4), .WINDOW(8)) u_a (
    .CK(CK), .CLR(CLR), .Q_in(Q_in), .START(START), .ACK(ACK),
    .RISE(rise[0]), .FALL(fall[0]), .BUSY(busy[0]), .VALID(valid[0]),
    .COUNT(count_a), .OVF(ovf[0])
  );

  jk_edge_counter #(.WIDTH(2), .WINDOW(16)) u_b (
    .CK(CK), .CLR(CLR), .Q_in(Q_in), .START(START), .ACK(ACK),
    .RISE(rise[1]), .FALL(fall[1]), .BUSY(busy[1]), .VALID(valid[1]),
    .COUNT(count_b), .OVF(ovf[1])
  );

  // Model: per instance, a measurement is "edges left to see" plus an unbounded rise tally;
  // the reported count is min(tally, 2^W-1), overflow is tally > 2^W-1.
  int win[2]  = '{8, 16};
  int maxc[2] = '{15, 3};
  int m_phase[2];   // 0 waiting for start, 1 measuring, 2 holding result
  int m_left[2];
  int m_tally[2];
  int m_count[2];
  int m_ovf[2];
  int m_rise, m_fall, m_prev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic clr, input logic q, input logic st, input logic ack);
    int r, f;
    if (!clr) begin
      m_rise = 0; m_fall = 0; m_prev = q;
      for (int i = 0; i < 2; i++) begin
        m_phase[i] = 0; m_count[i] = 0; m_ovf[i] = 0; m_left[i] = 0; m_tally[i] = 0;
      end
      return;
    end
    r = (m_prev == 0 && q == 1) ? 1 : 0;
    f = (m_prev == 1 && q == 0) ? 1 : 0;
    m_rise = r; m_fall = f; m_prev = q;
    for (int i = 0; i < 2; i++) begin
      if (m_phase[i] == 0) begin
        if (st) begin m_phase[i] = 1; m_left[i] = win[i]; m_tally[i] = 0; end
      end else if (m_phase[i] == 1) begin
        m_tally[i] += r;
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_phase[i] = 2;
          m_count[i] = (m_tally[i] > maxc[i]) ? maxc[i] : m_tally[i];
          m_ovf[i]   = (m_tally[i] > maxc[i]) ? 1 : 0;
        end
      end else if (ack) begin
        m_phase[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("A.rise",  32'(rise[0]),  32'(m_rise));
    chk("A.fall",  32'(fall[0]),  32'(m_fall));
    chk("A.busy",  32'(busy[0]),  32'(m_phase[0] == 1));
    chk("A.valid", 32'(valid[0]), 32'(m_phase[0] == 2));
    chk("A.count", 32'(count_a),  32'(m_count[0]));
    chk("A.ovf",   32'(ovf[0]),   32'(m_ovf[0]));
    chk("B.rise",  32'(rise[1]),  32'(m_rise));
    chk("B.fall",  32'(fall[1]),  32'(m_fall));
    chk("B.busy",  32'(busy[1]),  32'(m_phase[1] == 1));
    chk("B.valid", 32'(valid[1]), 32'(m_phase[1] == 2));
    chk("B.count", 32'(count_b),  32'(m_count[1]));
    chk("B.ovf",   32'(ovf[1]),   32'(m_ovf[1]));
  endtask

  // One clock: drive inputs, let the edge happen, then advance the model and compare.
  task automatic cyc(input logic clr, input logic q, input logic st, input logic ack);
    CLR = clr; Q_in = q; START = st; ACK = ack;
    @(posedge CK);
    #1;
    model_edge(clr, q, st, ack);
    check_all();
  endtask

  task automatic release_both(input logic q);
    cyc(1'b1, q, 1'b0, 1'b1);
    cyc(1'b1, q, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset with Q_in already high; no RISE after release.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("preset.rise", 32'(rise[0]), 32'd0);
    end
    chk("preset.busy", 32'(busy[0]), 32'd0);

    // Toggle mode: Q alternates starting at 0 on the START edge.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b1, 1'(k % 2), 1'b0, 1'b0);
      if (k == 7) chk("tog.A.busy_last", 32'(busy[0]), 32'd1);
      if (k == 8) begin
        chk("tog.A.valid", 32'(valid[0]), 32'd1);
        chk("tog.A.count", 32'(count_a), 32'd4);
        chk("tog.A.ovf",   32'(ovf[0]),   32'd0);
      end
    end
    chk("sat.B.count", 32'(count_b), 32'd3);
    chk("sat.B.ovf",   32'(ovf[1]),  32'd1);

    // Withheld ACK with START pulses: result held, no new run.
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 1'(k == 2), 1'b0);
    chk("hold.A.valid", 32'(valid[0]), 32'd1);
    chk("hold.A.count", 32'(count_a),  32'd4);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    chk("startack.busy",  32'(busy[0]),  32'd0);
    chk("startack.valid", 32'(valid[0]), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("startack.busy2", 32'(busy[0]), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("idleack.count", 32'(count_a), 32'd4);

    // Static low, then static high.
    for (int s = 0; s < 2; s++) begin
      cyc(1'b1, 1'(s), 1'b0, 1'b0);
      cyc(1'b1, 1'(s), 1'b1, 1'b0);
      for (int k = 0; k < 16; k++) cyc(1'b1, 1'(s), 1'b0, 1'b0);
      chk("static.A.count", 32'(count_a), 32'd0);
      chk("static.B.count", 32'(count_b), 32'd0);
      chk("static.B.ovf",   32'(ovf[1]),  32'd0);
      release_both(1'(s));
    end

    // Reset in the 4th RUN cycle after two rises, then a fresh full window.
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst.busy",  32'(busy[0]),  32'd0);
    chk("midrst.count", 32'(count_a),  32'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 1'(k % 2), 1'b0, 1'b0);
      if (k == 7) chk("fresh.A.busy", 32'(busy[0]), 32'd1);
    end
    chk("fresh.A.valid", 32'(valid[0]), 32'd1);
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    release_both(1'b0);

    // Random traffic with occasional resets.
    for (int k = 0; k < 800; k++)
      cyc(1'($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
